// File: rtl/fm_demod_conj_mult.sv
// ---------------------------------------------------------------------------
// fm_demod_conj_mult
//
// Conjugate-multiply stage of the FM demodulator. Each filtered I/Q sample
// is multiplied by the complex conjugate of the previous sample:
//   real = DQ(prev_r*cur_r + prev_i*cur_i)
//   imag = DQ(prev_r*cur_i - prev_i*cur_r)
// where every product, sum and difference wraps at 32 bits (C int), and
// DQ(v) = v / 2^BITS truncated toward zero. The real part feeds the qarctan
// x/inB FIFO, the imaginary part feeds the y/inA FIFO.
//
// Parameters
//   BITS            quantization shift (dequantize divides by 2^BITS)
//
// Ports
//   clock           rising-edge clock
//   reset           synchronous, active-high reset
//   in_real_*       I-sample FIFO (first-word-fall-through): rd_en/empty/dout
//   in_imag_*       Q-sample FIFO (first-word-fall-through): rd_en/empty/dout
//   out_real_*      x FIFO write side: wr_en/full/din
//   out_imag_*      y FIFO write side: wr_en/full/din
//
// Configuration macro
//   FM_DEMOD_DROP_FIRST_EN  when defined, the first pair after reset only
//                           primes prev_r/prev_i and produces no output.
// ---------------------------------------------------------------------------
module fm_demod_conj_mult #(
    parameter int BITS = 10
) (
    input  logic               clock,
    input  logic               reset,

    output logic               in_real_rd_en,
    input  logic               in_real_empty,
    input  logic signed [31:0] in_real_dout,

    output logic               in_imag_rd_en,
    input  logic               in_imag_empty,
    input  logic signed [31:0] in_imag_dout,

    output logic               out_real_wr_en,
    input  logic               out_real_full,
    output logic signed [31:0] out_real_din,

    output logic               out_imag_wr_en,
    input  logic               out_imag_full,
    output logic signed [31:0] out_imag_din
);

    typedef enum logic [1:0] {
        S_READ,
        S_MULT,
        S_SUM,
        S_WRITE
    } state_t;

    state_t state;

    logic signed [31:0] cur_r;
    logic signed [31:0] cur_i;
    logic signed [31:0] prev_r;
    logic signed [31:0] prev_i;
    logic signed [31:0] p_rr;   // prev_r * cur_r
    logic signed [31:0] p_ii;   // prev_i * cur_i
    logic signed [31:0] p_ri;   // prev_r * cur_i
    logic signed [31:0] p_ir;   // prev_i * cur_r

`ifdef FM_DEMOD_DROP_FIRST_EN
    logic primed;
`endif

    logic both_avail;
    logic both_room;

    assign both_avail = !in_real_empty && !in_imag_empty;
    assign both_room  = !out_real_full && !out_imag_full;

    // NOTE: the FIFO strobes are decoded from state instead of being
    // registered, so a write can never land in a cycle where either full is
    // high and a pop always coincides with the FWFT word being captured.
    // Gating with reset keeps them low while reset is held.
    assign in_real_rd_en  = !reset && (state == S_READ)  && both_avail;
    assign in_imag_rd_en  = !reset && (state == S_READ)  && both_avail;
    assign out_real_wr_en = !reset && (state == S_WRITE) && both_room;
    assign out_imag_wr_en = !reset && (state == S_WRITE) && both_room;

    // Divide by 2^BITS rounding toward zero: negative values are biased by
    // 2^BITS-1 before the arithmetic shift so they do not round toward -inf.
    // The bias is only added to negative values, so it cannot overflow.
    function automatic logic signed [31:0] dequant(input logic signed [31:0] v);
        logic signed [31:0] bias;
        bias = v[31] ? ((32'sd1 <<< BITS) - 32'sd1) : 32'sd0;
        return (v + bias) >>> BITS;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_READ;
            cur_r        <= '0;
            cur_i        <= '0;
            prev_r       <= '0;
            prev_i       <= '0;
            p_rr         <= '0;
            p_ii         <= '0;
            p_ri         <= '0;
            p_ir         <= '0;
            out_real_din <= '0;
            out_imag_din <= '0;
`ifdef FM_DEMOD_DROP_FIRST_EN
            primed       <= 1'b0;
`endif
        end else begin
            case (state)
                S_READ: begin
                    if (both_avail) begin
                        cur_r <= in_real_dout;
                        cur_i <= in_imag_dout;
                        state <= S_MULT;
                    end
                end

                S_MULT: begin
                    // NOTE: non-blocking assignments make the products see
                    // the old prev_* while prev_* is reloaded on the same edge.
                    p_rr   <= prev_r * cur_r;
                    p_ii   <= prev_i * cur_i;
                    p_ri   <= prev_r * cur_i;
                    p_ir   <= prev_i * cur_r;
                    prev_r <= cur_r;
                    prev_i <= cur_i;
`ifdef FM_DEMOD_DROP_FIRST_EN
                    if (!primed) begin
                        primed <= 1'b1;
                        state  <= S_READ;
                    end else begin
                        state  <= S_SUM;
                    end
`else
                    state  <= S_SUM;
`endif
                end

                S_SUM: begin
                    out_real_din <= dequant(p_rr + p_ii);
                    out_imag_din <= dequant(p_ri - p_ir);
                    state        <= S_WRITE;
                end

                S_WRITE: begin
                    // Hold din until both sinks have room; the pair is
                    // always pushed together.
                    if (both_room) begin
                        state <= S_READ;
                    end
                end

                default: state <= S_READ;
            endcase
        end
    end

endmodule

// File: tb/tb_fm_demod_conj_mult.sv
// ---------------------------------------------------------------------------
// tb_fm_demod_conj_mult
//
// Directed bench for fm_demod_conj_mult (BITS = 10). Inputs are driven on
// the falling edge, outputs sampled 1 time unit later. Expected outputs are
// hand-computed from the previous/current sample pairs.
// ---------------------------------------------------------------------------
module tb_fm_demod_conj_mult;

    logic               clock;
    logic               reset;
    logic               in_real_rd_en;
    logic               in_real_empty;
    logic signed [31:0] in_real_dout;
    logic               in_imag_rd_en;
    logic               in_imag_empty;
    logic signed [31:0] in_imag_dout;
    logic               out_real_wr_en;
    logic               out_real_full;
    logic signed [31:0] out_real_din;
    logic               out_imag_wr_en;
    logic               out_imag_full;
    logic signed [31:0] out_imag_din;

    int passed = 0;
    int total  = 0;

    fm_demod_conj_mult #(.BITS(10)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_real_rd_en  (in_real_rd_en),
        .in_real_empty  (in_real_empty),
        .in_real_dout   (in_real_dout),
        .in_imag_rd_en  (in_imag_rd_en),
        .in_imag_empty  (in_imag_empty),
        .in_imag_dout   (in_imag_dout),
        .out_real_wr_en (out_real_wr_en),
        .out_real_full  (out_real_full),
        .out_real_din   (out_real_din),
        .out_imag_wr_en (out_imag_wr_en),
        .out_imag_full  (out_imag_full),
        .out_imag_din   (out_imag_din)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Offer one pair on both FIFOs, wait (bounded) for the joint pop, then
    // empty the FIFOs right after the popping edge.
    task automatic send_pair(input string tag, input logic signed [31:0] r,
                             input logic signed [31:0] i);
        int n;
        @(negedge clock);
        in_real_dout  = r;
        in_imag_dout  = i;
        in_real_empty = 1'b0;
        in_imag_empty = 1'b0;
        #1;
        n = 0;
        while (!(in_real_rd_en || in_imag_rd_en) && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        check({tag, "_pop"}, {30'd0, in_real_rd_en, in_imag_rd_en}, 32'sd3);
        @(posedge clock);
        #1;
        in_real_empty = 1'b1;
        in_imag_empty = 1'b1;
    endtask

    // Called right after the pop edge: expect the joint write 3 cycles
    // after the pop cycle, with the given data.
    task automatic wait_write(input string tag, input logic signed [31:0] er,
                              input logic signed [31:0] ei);
        int lat;
        lat = 0;
        do begin
            @(negedge clock);
            #1;
            lat++;
        end while (!(out_real_wr_en || out_imag_wr_en) && lat < 20);
        check({tag, "_latency"}, lat, 3);
        check({tag, "_wr_pair"}, {30'd0, out_real_wr_en, out_imag_wr_en}, 32'sd3);
        check({tag, "_real"}, out_real_din, er);
        check({tag, "_imag"}, out_imag_din, ei);
        @(posedge clock);
        #1;
    endtask

`ifdef FM_DEMOD_DROP_FIRST_EN
    task automatic wait_no_write(input string tag);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            #1;
            check({tag, "_no_write"}, {30'd0, out_real_wr_en, out_imag_wr_en}, 32'sd0);
        end
    endtask
`endif

    initial begin
        reset         = 1'b1;
        in_real_empty = 1'b0;   // data pending during reset must not pop
        in_imag_empty = 1'b0;
        in_real_dout  = 32'sd7;
        in_imag_dout  = 32'sd7;
        out_real_full = 1'b0;
        out_imag_full = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        check("rst_rd_en",  {30'd0, in_real_rd_en, in_imag_rd_en}, 32'sd0);
        check("rst_wr_en",  {30'd0, out_real_wr_en, out_imag_wr_en}, 32'sd0);
        check("rst_real",   out_real_din, 32'sd0);
        check("rst_imag",   out_imag_din, 32'sd0);
        in_real_empty = 1'b1;
        in_imag_empty = 1'b1;
        reset         = 1'b0;

        // ---- first pair against prev = 0, then a 90-degree step ----
        send_pair("p1", 32'sd1024, 32'sd0);
`ifdef FM_DEMOD_DROP_FIRST_EN
        wait_no_write("p1");
`else
        wait_write("p1", 32'sd0, 32'sd0);
`endif
        send_pair("p2", 32'sd0, 32'sd1024);
        wait_write("p2", 32'sd0, 32'sd1024);

        // ---- truncation toward zero ----
        send_pair("p3", -32'sd1000, 32'sd0);      // prev (0,1024)
        wait_write("p3", 32'sd0, 32'sd1000);
        send_pair("trunc", 32'sd1500, 32'sd0);    // -1500000/1024
        wait_write("trunc", -32'sd1464, 32'sd0);

        // ---- 32-bit product wrap ----
        send_pair("p5", 32'sd65536, 32'sd0);      // 1500*65536/1024
        wait_write("p5", 32'sd96000, 32'sd0);
        send_pair("wrap", 32'sd65536, 32'sd0);    // 2^32 wraps to 0
        wait_write("wrap", 32'sd0, 32'sd0);

        // ---- backpressure on the y FIFO ----
        @(negedge clock);
        out_imag_full = 1'b1;
        send_pair("bp", 32'sd0, 32'sd2048);       // 65536*2048/1024
        @(negedge clock);                         // MULT
        @(negedge clock);                         // SUM
        in_real_dout  = 32'sd1024;                // next pair waits upstream
        in_imag_dout  = 32'sd0;
        in_real_empty = 1'b0;
        in_imag_empty = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            #1;
            check("bp_wr_held", {30'd0, out_real_wr_en, out_imag_wr_en}, 32'sd0);
            check("bp_rd_held", {30'd0, in_real_rd_en, in_imag_rd_en}, 32'sd0);
            check("bp_real",    out_real_din, 32'sd0);
            check("bp_imag",    out_imag_din, 32'sd131072);
        end
        @(negedge clock);
        out_imag_full = 1'b0;
        #1;
        check("bp_release_wr", {30'd0, out_real_wr_en, out_imag_wr_en}, 32'sd3);
        check("bp_release_imag", out_imag_din, 32'sd131072);
        @(posedge clock);
        #1;
        check("bp_single_write", {30'd0, out_real_wr_en, out_imag_wr_en}, 32'sd0);
        send_pair("p8", 32'sd1024, 32'sd0);       // prev (0,2048)
        wait_write("p8", 32'sd0, -32'sd2048);

        // ---- input skew: only the I FIFO has data ----
        @(negedge clock);
        in_real_dout  = 32'sd1024;
        in_real_empty = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            #1;
            check("skew_no_pop", {30'd0, in_real_rd_en, in_imag_rd_en}, 32'sd0);
        end
        send_pair("skew", 32'sd1024, 32'sd1024);  // prev (1024,0)
        wait_write("skew", 32'sd1024, 32'sd1024);

        // ---- reset during SUM clears prev and outputs ----
        send_pair("pre_rst", 32'sd2048, 32'sd0);
        @(negedge clock);                         // MULT
        @(negedge clock);                         // SUM
        reset         = 1'b1;
        in_real_dout  = 32'sd5120;
        in_imag_dout  = 32'sd0;
        in_real_empty = 1'b0;
        in_imag_empty = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            check("mid_rst_real",  out_real_din, 32'sd0);
            check("mid_rst_imag",  out_imag_din, 32'sd0);
            check("mid_rst_wr_en", {30'd0, out_real_wr_en, out_imag_wr_en}, 32'sd0);
            check("mid_rst_rd_en", {30'd0, in_real_rd_en, in_imag_rd_en}, 32'sd0);
        end
        @(negedge clock);
        in_real_empty = 1'b1;
        in_imag_empty = 1'b1;
        reset         = 1'b0;
        send_pair("post_rst", 32'sd5120, 32'sd0);
`ifdef FM_DEMOD_DROP_FIRST_EN
        wait_no_write("post_rst");
`else
        wait_write("post_rst", 32'sd0, 32'sd0);
`endif
        send_pair("last", 32'sd0, 32'sd1024);     // prev (5120,0)
        wait_write("last", 32'sd0, 32'sd5120);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule
